// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI byte transmit engine.
//   spi_state_t : transfer FSM states.
//   spi_out_t   : registered output bundle of spi_byte_tx.
//   SPI_BYTE_W, SPI_CLK_DIV_DEFAULT : byte width and default SCK half-period.
package spi_pkg;

  localparam int SPI_BYTE_W          = 8;
  localparam int SPI_CLK_DIV_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    FINISH = 3'd4
  } spi_state_t;

  typedef struct packed {
    logic sclk;
    logic mosi;
    logic ss_n;
    logic serclk;
    logic busy;
    logic done;
    logic overrun;
  } spi_out_t;

  // Values every output register takes while reset is asserted.
  function automatic spi_out_t spi_out_reset();
    spi_out_t o;
    o.sclk    = 1'b0;
    o.mosi    = 1'b0;
    o.ss_n    = 1'b1;
    o.serclk  = 1'b1;
    o.busy    = 1'b0;
    o.done    = 1'b0;
    o.overrun = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/spi_byte_tx_if.sv
// spi_byte_tx_if: CPU-side write port of the SPI byte transmit engine.
//   wr_data   : byte to send, sampled with wr_strobe.
//   wr_strobe : one-cycle start pulse.
//   cs_hold   : keep ss_n low after the byte for multi-byte frames.
//   busy      : transfer in progress.
//   done      : one-cycle end-of-transfer pulse.
//   overrun   : sticky, a strobe arrived while busy.
//
// Handshake: a wr_strobe is accepted only in a cycle where busy is low; the
// byte is then owned by the engine until the done pulse. A strobe seen while
// busy is high (including the done cycle) is dropped and raises overrun.
interface spi_byte_tx_if;
  import spi_pkg::*;

  logic [SPI_BYTE_W-1:0] wr_data;
  logic                  wr_strobe;
  logic                  cs_hold;
  logic                  busy;
  logic                  done;
  logic                  overrun;

  modport master (
    output wr_data, wr_strobe, cs_hold,
    input  busy, done, overrun
  );

  modport slave (
    input  wr_data, wr_strobe, cs_hold,
    output busy, done, overrun
  );

endinterface

// File: rtl/sck_halfcnt.sv
// sck_halfcnt: SCK half-period down-counter.
//   clk, reset : system clock, synchronous active-high reset.
//   load       : reload with CLK_DIV-1 (asserted on every state entry).
//   tc         : terminal count, high when the counter is at zero.
// With CLK_DIV=1 the counter is permanently zero, so every state lasts 1 cycle.
module sck_halfcnt #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tc
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= RELOAD;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: byte-wide SPI mode-0 master transmitter.
//   clk, reset : system clock, synchronous active-high reset.
//   bus        : CPU write port (wr_data/wr_strobe/cs_hold in, busy/done/overrun out).
//   sclk       : SPI clock, idles low.
//   mosi       : serial data, MSB first.
//   ss_n       : slave select, active low.
//   serclk     : ~sclk while busy, idles high; falling edge is the shiftreg_in capture point.
//   shift_en   : shiftreg_in enable, equals busy.
//   dbg_state  : current FSM state.
// Every output comes straight from a flop; next values are decoded from the
// next state so nothing combinational reaches a pin.
module spi_byte_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  spi_byte_tx_if.slave  bus,
  output logic          sclk,
  output logic          mosi,
  output logic          ss_n,
  output logic          serclk,
  output logic          shift_en,
  output spi_state_t    dbg_state
);

  spi_state_t state_q, state_n;
  // Bit 7 goes to mosi immediately on the strobe, so only the remaining
  // seven bits need to be held for shifting.
  logic [SPI_BYTE_W-2:0] txreg_q, txreg_n;
  logic [2:0]            bitcnt_q, bitcnt_n;
  // Set when the last bit's HIGH phase ends, so the following LOW exits to FINISH.
  logic                  last_q, last_n;
  spi_out_t              out_q, out_n;
  logic                  tc;
  logic                  cnt_load;

  // Reload on every state change; IDLE and FINISH keep it primed so the next
  // state starts with a full half-period.
  assign cnt_load = (state_q == IDLE) || (state_q == FINISH) || tc;

  sck_halfcnt #(.CLK_DIV(CLK_DIV)) u_halfcnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      txreg_q  <= '0;
      bitcnt_q <= '0;
      last_q   <= 1'b0;
      out_q    <= spi_out_reset();
    end else begin
      state_q  <= state_n;
      txreg_q  <= txreg_n;
      bitcnt_q <= bitcnt_n;
      last_q   <= last_n;
      out_q    <= out_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    txreg_n  = txreg_q;
    bitcnt_n = bitcnt_q;
    last_n   = last_q;
    out_n    = out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.wr_strobe) begin
          state_n       = SETUP;
          txreg_n       = bus.wr_data[SPI_BYTE_W-2:0];
          bitcnt_n      = 3'd7;
          last_n        = 1'b0;
          out_n.mosi    = bus.wr_data[SPI_BYTE_W-1];
          out_n.ss_n    = 1'b0;
          out_n.overrun = 1'b0;
        end else if (!bus.cs_hold) begin
          out_n.ss_n = 1'b1;
        end
      end
      SETUP: begin
        if (tc) state_n = HIGH;
      end
      HIGH: begin
        if (tc) begin
          state_n = LOW;
          // Data changes only as sclk falls, giving a full half-period of setup.
          if (bitcnt_q != 3'd0) begin
            out_n.mosi = txreg_q[SPI_BYTE_W-2];
            txreg_n    = {txreg_q[SPI_BYTE_W-3:0], 1'b0};
            bitcnt_n   = bitcnt_q - 3'd1;
          end else begin
            last_n = 1'b1;
          end
        end
      end
      LOW: begin
        if (tc) begin
          if (last_q) begin
            state_n    = FINISH;
            out_n.ss_n = ~bus.cs_hold;
          end else begin
            state_n = HIGH;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (bus.wr_strobe && (state_q != IDLE)) out_n.overrun = 1'b1;

    out_n.sclk   = (state_n == HIGH);
    out_n.serclk = ~out_n.sclk;
    out_n.busy   = (state_n != IDLE);
    out_n.done   = (state_n == FINISH);
  end

  assign bus.busy    = out_q.busy;
  assign bus.done    = out_q.done;
  assign bus.overrun = out_q.overrun;
  assign sclk        = out_q.sclk;
  assign mosi        = out_q.mosi;
  assign ss_n        = out_q.ss_n;
  assign serclk      = out_q.serclk;
  assign shift_en    = out_q.busy;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: directed bench for spi_byte_tx. Two instances (CLK_DIV=4 and
// CLK_DIV=1) share the stimulus; sel picks which one is driven and observed.
// A monitor collects mosi on sclk rises, models shiftreg_in on serclk falls
// with MISO looped to mosi, and checks each done pulse against exp_q.
module tb_spi_byte_tx;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  logic [7:0] wr_data = 8'h00;
  logic       wr_strobe = 1'b0;
  logic       cs_hold = 1'b0;
  logic       sel = 1'b0;

  spi_byte_tx_if bus4();
  spi_byte_tx_if bus1();

  assign bus4.wr_data   = wr_data;
  assign bus4.wr_strobe = wr_strobe & ~sel;
  assign bus4.cs_hold   = cs_hold;
  assign bus1.wr_data   = wr_data;
  assign bus1.wr_strobe = wr_strobe & sel;
  assign bus1.cs_hold   = cs_hold;

  logic sclk4, mosi4, ss_n4, serclk4, shift_en4;
  logic sclk1, mosi1, ss_n1, serclk1, shift_en1;
  spi_state_t dbg4, dbg1;

  spi_byte_tx #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4),
    .sclk(sclk4), .mosi(mosi4), .ss_n(ss_n4), .serclk(serclk4),
    .shift_en(shift_en4), .dbg_state(dbg4)
  );

  spi_byte_tx #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .sclk(sclk1), .mosi(mosi1), .ss_n(ss_n1), .serclk(serclk1),
    .shift_en(shift_en1), .dbg_state(dbg1)
  );

  logic mon_sclk, mon_mosi, mon_ss_n, mon_serclk, mon_shift_en;
  logic mon_busy, mon_done, mon_overrun;
  spi_state_t mon_state;
  int cur_div;

  assign mon_sclk     = sel ? sclk1     : sclk4;
  assign mon_mosi     = sel ? mosi1     : mosi4;
  assign mon_ss_n     = sel ? ss_n1     : ss_n4;
  assign mon_serclk   = sel ? serclk1   : serclk4;
  assign mon_shift_en = sel ? shift_en1 : shift_en4;
  assign mon_busy     = sel ? bus1.busy    : bus4.busy;
  assign mon_done     = sel ? bus1.done    : bus4.done;
  assign mon_overrun  = sel ? bus1.overrun : bus4.overrun;
  assign mon_state    = sel ? dbg1 : dbg4;
  assign cur_div      = sel ? 1 : 4;

  // ---------------- check bookkeeping ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [7:0] rx_bits = 8'h00;
  logic [7:0] loop_sr = 8'h00;
  int rises = 0, falls = 0, busy_cnt = 0, busy_n = 0, done_cnt = 0;
  logic [7:0] exp_byte;
  int         exp_cyc;

  always @(posedge mon_sclk) begin
    rx_bits = {rx_bits[6:0], mon_mosi};
    rises++;
  end

  // shiftreg_in model: MISO looped back to mosi, captured on serclk fall.
  always @(negedge mon_serclk) begin
    if (mon_shift_en) begin
      loop_sr = {loop_sr[6:0], mon_mosi};
      falls++;
    end
  end

  always @(negedge clk) begin
    busy_n = busy_cnt + (mon_busy ? 1 : 0);
    if (mon_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_done: done pulse with empty expected queue (t=%0t)", $time);
      end else begin
        exp_byte = exp_q.pop_front();
        exp_cyc  = exp_cyc_q.pop_front();
        check("mosi_stream",  rx_bits, exp_byte);
        check("loopback",     loop_sr, exp_byte);
        check("sclk_rises",   rises, 8);
        check("serclk_falls", falls, 8);
        check("done_cycle",   cyc, exp_cyc);
        check("busy_length",  busy_n, 17 * cur_div + 1);
      end
      rises  = 0;
      falls  = 0;
      busy_n = 0;
    end
    busy_cnt = busy_n;
  end

  logic ss_watch = 1'b0, ss_glitch = 1'b0;
  always @(negedge clk) if (ss_watch && mon_ss_n) ss_glitch = 1'b1;

  int  edge_cnt = 0;
  logic edge_en = 1'b0;
  always @(mon_sclk or mon_mosi or mon_ss_n or mon_serclk or mon_shift_en or
           mon_busy or mon_done or mon_overrun)
    if (edge_en) edge_cnt++;

  // ---------------- driver tasks ----------------
  // Strobe lands in cycle 0 (cyc value k); done is due with cyc = k+1+17*div.
  task automatic write_byte(input logic [7:0] d, input bit expect_tx);
    @(posedge clk);
    #1;
    wr_data   = d;
    wr_strobe = 1'b1;
    if (expect_tx) begin
      exp_q.push_back(d);
      exp_cyc_q.push_back(cyc + 1 + 17 * cur_div);
    end
    @(posedge clk);
    #1;
    wr_strobe = 1'b0;
  endtask

  // Called right after write_byte: checks cycle-1 outputs and the first sclk rise.
  task automatic check_start(input logic bit7);
    @(negedge clk);
    check("start_busy", mon_busy, 1'b1);
    check("start_ss_n", mon_ss_n, 1'b0);
    check("start_mosi", mon_mosi, bit7);
    repeat (cur_div - 1) @(negedge clk);
    check("sclk_before_rise", mon_sclk, 1'b0);
    @(negedge clk);
    check("sclk_first_rise", mon_sclk, 1'b1);
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (mon_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sclk"},     mon_sclk, 1'b0);
    check({tag, "_serclk"},   mon_serclk, 1'b1);
    check({tag, "_mosi"},     mon_mosi, 1'b0);
    check({tag, "_ss_n"},     mon_ss_n, 1'b1);
    check({tag, "_busy"},     mon_busy, 1'b0);
    check({tag, "_done"},     mon_done, 1'b0);
    check({tag, "_overrun"},  mon_overrun, 1'b0);
    check({tag, "_shift_en"}, mon_shift_en, 1'b0);
    check({tag, "_state"},    mon_state, IDLE);
  endtask

  // ---------------- test sequence ----------------
  int done_before, falls_before;
  bit hit;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    rises = 0; falls = 0; busy_cnt = 0;

    // Idle: 20 cycles with no output activity.
    edge_en = 1'b1;
    repeat (20) @(negedge clk);
    edge_en = 1'b0;
    check("idle_edges", edge_cnt, 0);
    check("idle_ss_n", mon_ss_n, 1'b1);

    // CLK_DIV=4, 0xA5.
    sel = 1'b0;
    write_byte(8'hA5, 1'b1);
    check_start(1'b1);
    wait_done(200);
    @(negedge clk);
    check("a5_idle_busy", mon_busy, 1'b0);
    check("a5_idle_sclk", mon_sclk, 1'b0);

    // CLK_DIV=1, 0x3C.
    sel = 1'b1;
    write_byte(8'h3C, 1'b1);
    check_start(1'b0);
    wait_done(100);
    repeat (2) @(negedge clk);

    // Overrun: second strobe 10 cycles into 0xFF.
    sel = 1'b0;
    write_byte(8'hFF, 1'b1);
    repeat (9) @(posedge clk);
    write_byte(8'h00, 1'b0);
    @(negedge clk);
    check("overrun_set", mon_overrun, 1'b1);
    check("overrun_busy", mon_busy, 1'b1);
    wait_done(200);
    repeat (2) @(negedge clk);
    check("overrun_sticky", mon_overrun, 1'b1);
    write_byte(8'h5A, 1'b1);
    @(negedge clk);
    check("overrun_cleared", mon_overrun, 1'b0);
    wait_done(200);
    repeat (2) @(negedge clk);

    // cs_hold back-to-back.
    cs_hold = 1'b1;
    write_byte(8'h01, 1'b1);
    ss_watch = 1'b1;
    wait_done(200);
    write_byte(8'h80, 1'b1);
    wait_done(200);
    @(negedge clk);
    ss_watch = 1'b0;
    check("cs_hold_no_release", ss_glitch, 1'b0);
    check("cs_hold_idle_ss_n", mon_ss_n, 1'b0);
    @(posedge clk);
    #1 cs_hold = 1'b0;
    @(negedge clk);
    check("cs_drop_same_cycle", mon_ss_n, 1'b0);
    @(negedge clk);
    check("cs_drop_release", mon_ss_n, 1'b1);

    // Reset during the 4th HIGH phase.
    write_byte(8'hC3, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rises == 4 && mon_sclk) begin
        hit = 1'b1;
        break;
      end
    end
    check("reset_reach_high4", hit, 1'b1);
    done_before  = done_cnt;
    falls_before = falls;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    check("abort_no_done", done_cnt, done_before);
    check("abort_no_fall", falls, falls_before);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_done_after", done_cnt, done_before);
    check("abort_busy_after", mon_busy, 1'b0);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
